// File: rtl/pe_result_drain.sv
// pe_result_drain: drain end of the systolic PE array.
// Deskews the staggered bottom-row results into whole rows, buffers them in a
// row FIFO and serialises each row one word per valid/ready handshake.
module pe_result_drain #(
  parameter int COLS  = 4,
  parameter int DW    = 32,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [COLS*DW-1:0]       res_in,
  input  logic                     res_valid,
  output logic [DW-1:0]            out_data,
  output logic [$clog2(COLS)-1:0]  out_col,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic                     out_last,
  output logic [$clog2(DEPTH):0]   fifo_level,
  output logic                     overflow
);

  localparam int CW = $clog2(COLS);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  typedef enum logic {IDLE, SEND} state_t;

  // Row as seen after the deskew registers, one word per column
  logic [DW-1:0] aligned_row [COLS];

  // Column c arrives c cycles after column 0, so it needs COLS-1-c delay
  // stages to line up with the last column, which is used directly.
  for (genvar c = 0; c < COLS; c++) begin : g_col
    localparam int D = COLS - 1 - c;
    if (D == 0) begin : g_nodly
      assign aligned_row[c] = res_in[c*DW +: DW];
    end else begin : g_dly
      logic [DW-1:0] pipe_q [D];
      logic [DW-1:0] pipe_d [D];

      // Shift the column word one stage further down its delay line
      always_comb begin
        pipe_d[0] = res_in[c*DW +: DW];
        for (int k = 1; k < D; k++) begin
          pipe_d[k] = pipe_q[k-1];
        end
      end

      // Data stages carry no reset; only the strobe pipe decides validity
      always_ff @(posedge clk) begin
        pipe_q <= pipe_d;
      end

      assign aligned_row[c] = pipe_q[D-1];
    end
  end

  // Strobe delay line, COLS-1 stages, matching column 0's data delay
  logic [COLS-2:0] vpipe_q, vpipe_d;

  // Advance the row strobe alongside the data
  always_comb begin
    vpipe_d    = '0;
    vpipe_d[0] = res_valid;
    for (int k = 1; k < COLS - 1; k++) begin
      vpipe_d[k] = vpipe_q[k-1];
    end
  end

  // Clearing the strobe pipe on reset kills every row still in flight
  always_ff @(posedge clk) begin
    if (!rst_n) vpipe_q <= '0;
    else        vpipe_q <= vpipe_d;
  end

  logic push_strobe;
  assign push_strobe = vpipe_q[COLS-2];

  // Row FIFO storage and control
  logic [DW-1:0] mem_q [DEPTH][COLS];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [LW-1:0] level_q, level_d;
  logic          overflow_q, overflow_d;
  state_t        state_q, state_d;
  logic [CW-1:0] col_q, col_d;

  logic full, handshake, pop, push_ok;

  // Push/pop decisions; a full FIFO still takes a row when the head leaves
  // in the same cycle, so the level stays put instead of dropping data
  always_comb begin
    full       = (level_q == LW'(DEPTH));
    handshake  = (state_q == SEND) && out_ready;
    pop        = handshake && (col_q == CW'(COLS - 1));
    push_ok    = push_strobe && (!full || pop);
    overflow_d = overflow_q | (push_strobe && !push_ok);
    wr_ptr_d   = push_ok ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d   = pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
    level_d    = level_q;
    case ({push_ok, pop})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase
  end

  // Row storage write; pointers alone define what is valid
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= aligned_row;
  end

  // FIFO bookkeeping registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      overflow_q <= overflow_d;
    end
  end

  // Serialiser state register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      col_q   <= '0;
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
    end
  end

  // Next-state: IDLE looks at the post-push level so a row landing in an
  // empty FIFO is presented on the very next cycle
  always_comb begin
    state_d = state_q;
    col_d   = col_q;
    case (state_q)
      IDLE: begin
        if (level_d != '0) begin
          state_d = SEND;
          col_d   = '0;
        end
      end
      SEND: begin
        if (handshake) begin
          if (pop) begin
            col_d = '0;
            if (level_d == '0) state_d = IDLE;
          end else begin
            col_d = col_q + CW'(1);
          end
        end
      end
      default: begin
        state_d = IDLE;
        col_d   = '0;
      end
    endcase
  end

  // Output decode; everything is driven from registers so it holds while stalled
  always_comb begin
    out_valid = 1'b0;
    out_data  = '0;
    out_col   = '0;
    out_last  = 1'b0;
    if (state_q == SEND) begin
      out_valid = 1'b1;
      out_data  = mem_q[rd_ptr_q][col_q];
      out_col   = col_q;
      out_last  = (col_q == CW'(COLS - 1));
    end
  end

  assign fifo_level = level_q;
  assign overflow   = overflow_q;

endmodule

// File: tb/tb_pe_result_drain.sv
// tb_pe_result_drain: directed bench for the PE result drain.
// A negedge monitor compares every presented word against a queue of
// expected words built from the rows the bench strobes in.
module tb_pe_result_drain;

  localparam int COLS  = 4;
  localparam int DW    = 32;
  localparam int DEPTH = 8;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic [COLS*DW-1:0]   res_in = '0;
  logic                 res_valid = 1'b0;
  logic [DW-1:0]        out_data;
  logic [1:0]           out_col;
  logic                 out_valid;
  logic                 out_ready = 1'b0;
  logic                 out_last;
  logic [3:0]           fifo_level;
  logic                 overflow;

  pe_result_drain #(.COLS(COLS), .DW(DW), .DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .res_in     (res_in),
    .res_valid  (res_valid),
    .out_data   (out_data),
    .out_col    (out_col),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_last   (out_last),
    .fifo_level (fifo_level),
    .overflow   (overflow)
  );

  // Free-running clock
  always #5 clk = ~clk;

  // Cycle counter, stepped on every rising edge
  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct packed {
    logic [DW-1:0] data;
    logic [1:0]    col;
    logic          last;
  } word_t;

  word_t       exp_q[$];
  word_t       popped;
  int unsigned hs_cyc[$];
  int          words_out = 0;
  int          checks = 0;
  int          errors = 0;
  int unsigned t0;
  int          words_before;
  logic [5:0]  ready_pat = 6'b100101;

  // Single comparison point: counts and reports
  task automatic checkOutput(input string tag, input logic [63:0] actual,
                             input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)",
               tag, actual, expected, cyc);
    end
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  // Strobe n consecutive rows with skewed columns; the first 'accept' rows go
  // into the expected-word queue. Word (r,c) = base + 16*r + c.
  task automatic applyStimulus(input int n, input int accept,
                               input logic [DW-1:0] base);
    word_t w;
    for (int r = 0; r < accept; r++) begin
      for (int c = 0; c < COLS; c++) begin
        w.data = base + DW'(16 * r + c);
        w.col  = 2'(c);
        w.last = (c == COLS - 1);
        exp_q.push_back(w);
      end
    end
    for (int k = 0; k < n + COLS - 1; k++) begin
      res_valid = (k < n);
      for (int c = 0; c < COLS; c++) begin
        if (k - c >= 0 && k - c < n)
          res_in[c*DW +: DW] = base + DW'(16 * (k - c) + c);
        else
          res_in[c*DW +: DW] = 32'hBAD0_0000 | DW'(c);
      end
      nextCycle();
    end
    res_valid = 1'b0;
  endtask

  // Step until every expected word has left, then confirm the block is idle
  task automatic waitDrain(input int budget);
    int n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      nextCycle();
      n++;
    end
    checkOutput("drain_pending", 64'(exp_q.size()), 64'd0);
    checkOutput("drain_valid", 64'(out_valid), 64'd0);
    checkOutput("drain_level", 64'(fifo_level), 64'd0);
  endtask

  // Compare every presented word with the model, stalled or not
  always @(negedge clk) begin
    if (rst_n && out_valid) begin
      if (exp_q.size() == 0) begin
        checkOutput("spurious_valid", 64'(out_valid), 64'd0);
      end else begin
        checkOutput("out_data", 64'(out_data), 64'(exp_q[0].data));
        checkOutput("out_col", 64'(out_col), 64'(exp_q[0].col));
        checkOutput("out_last", 64'(out_last), 64'(exp_q[0].last));
        if (out_ready) begin
          popped = exp_q.pop_front();
          words_out++;
          hs_cyc.push_back(cyc);
        end
      end
    end
  end

  // Safety net against a hung run
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  // Directed test sequence
  initial begin
    $display("[TB] start");
    rst_n = 1'b0;
    out_ready = 1'b0;
    repeat (3) nextCycle();
    checkOutput("rst_valid", 64'(out_valid), 64'd0);
    checkOutput("rst_last", 64'(out_last), 64'd0);
    checkOutput("rst_col", 64'(out_col), 64'd0);
    checkOutput("rst_data", 64'(out_data), 64'd0);
    checkOutput("rst_level", 64'(fifo_level), 64'd0);
    checkOutput("rst_overflow", 64'(overflow), 64'd0);
    rst_n = 1'b1;
    nextCycle();

    // 1: single row, words on t+4..t+7
    $display("[TB] test 1: single row latency");
    out_ready = 1'b1;
    hs_cyc.delete();
    t0 = cyc;
    applyStimulus(1, 1, 32'h10);
    waitDrain(20);
    checkOutput("t1_words", 64'(hs_cyc.size()), 64'd4);
    for (int i = 0; i < hs_cyc.size() && i < 4; i++)
      checkOutput("t1_cycle", 64'(hs_cyc[i] - t0), 64'(4 + i));

    // 2: three back-to-back rows stream with no gap
    $display("[TB] test 2: back-to-back rows");
    hs_cyc.delete();
    t0 = cyc;
    applyStimulus(3, 3, 32'h100);
    waitDrain(40);
    checkOutput("t2_words", 64'(hs_cyc.size()), 64'd12);
    for (int i = 0; i < hs_cyc.size() && i < 12; i++)
      checkOutput("t2_cycle", 64'(hs_cyc[i] - t0), 64'(4 + i));

    // 3: nine rows into an eight-row FIFO with ready low
    $display("[TB] test 3: overflow");
    out_ready = 1'b0;
    applyStimulus(9, 8, 32'h200);
    checkOutput("t3_level", 64'(fifo_level), 64'd8);
    checkOutput("t3_overflow", 64'(overflow), 64'd1);
    checkOutput("t3_head_data", 64'(out_data), 64'h200);
    words_before = words_out;
    out_ready = 1'b1;
    waitDrain(100);
    checkOutput("t3_words", 64'(words_out - words_before), 64'd32);
    checkOutput("t3_overflow_sticky", 64'(overflow), 64'd1);

    // 4: ready toggling with a stall on the last word of a row
    $display("[TB] test 4: stalls");
    out_ready = 1'b0;
    applyStimulus(2, 2, 32'h300);
    checkOutput("t4_level", 64'(fifo_level), 64'd2);
    for (int i = 0; i < 6; i++) begin
      out_ready = ready_pat[i];
      nextCycle();
    end
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      checkOutput("t4_stall_last", 64'(out_last), 64'd1);
      checkOutput("t4_stall_col", 64'(out_col), 64'd3);
      checkOutput("t4_stall_level", 64'(fifo_level), 64'd2);
      nextCycle();
    end
    out_ready = 1'b1;
    nextCycle();
    checkOutput("t4_pop_level", 64'(fifo_level), 64'd1);
    checkOutput("t4_pop_col", 64'(out_col), 64'd0);
    waitDrain(50);

    // 5: reset with three rows buffered and one row in flight
    $display("[TB] test 5: reset mid-row");
    out_ready = 1'b0;
    applyStimulus(3, 3, 32'h400);
    checkOutput("t5_level", 64'(fifo_level), 64'd3);
    res_valid = 1'b1;
    res_in = {4{32'h0000_04F0}};
    nextCycle();
    res_valid = 1'b0;
    nextCycle();
    rst_n = 1'b0;
    exp_q.delete();
    nextCycle();
    checkOutput("t5_valid", 64'(out_valid), 64'd0);
    checkOutput("t5_level_rst", 64'(fifo_level), 64'd0);
    checkOutput("t5_overflow", 64'(overflow), 64'd0);
    rst_n = 1'b1;
    out_ready = 1'b1;
    repeat (8) nextCycle();
    checkOutput("t5_quiet_valid", 64'(out_valid), 64'd0);
    checkOutput("t5_quiet_level", 64'(fifo_level), 64'd0);

    // 6: full FIFO, last-word pop coincides with an aligned push
    $display("[TB] test 6: push and pop while full");
    out_ready = 1'b0;
    applyStimulus(8, 8, 32'h500);
    checkOutput("t6_full", 64'(fifo_level), 64'd8);
    out_ready = 1'b1;
    applyStimulus(1, 1, 32'h600);
    checkOutput("t6_level", 64'(fifo_level), 64'd8);
    checkOutput("t6_overflow", 64'(overflow), 64'd0);
    checkOutput("t6_next_head", 64'(out_data), 64'h510);
    waitDrain(100);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
